transition_energy_monitor: RTL and testbench
============================================

// Module: transition_energy_monitor
// PURPOSE
//  Counts switching activity on gate-model output nets and reports dynamic
//  energy. The gate models count output 0->1 transitions inside the model;
//  this block takes those same nets at board level.
//  - Synchronises the nets and detects rising edges per net.
//  - Keeps per-net saturating counts and a weighted energy total.
//  - Serves snapshot reads over a req/valid/ack handshake.
// PARAMETERS
//  N_NETS      4   monitored nets (1..16)
//  CNT_W       16  per-net rise-counter width
//  E_W         24  energy-accumulator width
//  E_PER_RISE  1   energy units added per detected 0->1 transition
// PORTS
//  clk         in   1                 single system clock, rising edge
//  reset_L     in   1                 async active-low reset
//  nets        in   N_NETS            monitored gate outputs, asynchronous to clk
//  enable      in   1                 1: counting active; 0: counters hold
//  clear       in   1                 sync pulse: zero all counters and energy
//  rd_req      in   1                 read request, sampled in IDLE only
//  rd_sel      in   4                 net index; value N_NETS selects energy total
//  rd_valid    out  1                 rd_data/rd_sat valid, held until rd_ack
//  rd_data     out  E_W               zero-extended count, or energy total
//  rd_sat      out  1                 selected counter/accumulator saturated
//  rd_ack      in   1                 consumer accepted data
// BEHAVIOUR
//  - Reset (async assert, sync release): all outputs 0, sync/edge flops 0,
//    counters 0, energy 0, sat flags 0, FSM=IDLE.
//  - Input path: 2-flop synchroniser per net, then a prev flop.
//    rise[i] = s2[i] & ~prev[i].
//    Net edge -> counter update within 3 clk edges.
//  - With enable=1, each rise[i] increments cnt[i].
//    - cnt[i] at all-ones: holds, sets sat[i].
//    - energy += E_PER_RISE * popcount(rise) in the same cycle; it is
//      computed in E_W+4 bits, then saturates at all-ones and sets sat_e.
//  - enable=0: sync/edge pipeline keeps running (no stale edge on re-enable);
//    counters and energy hold.
//  - clear=1: zeroes counters, energy and sat flags next cycle.
//    clear wins over any rise in the same cycle.
//    Snapshot already in PRESENT is unaffected.
//  - Read FSM:
//    IDLE --rd_req--> LATCH: capture selected value and sat into snapshot.
//    LATCH --> PRESENT: rd_valid=1. rd_data/rd_sat stay stable while rd_valid=1.
//    PRESENT --rd_ack--> IDLE: rd_valid=0 next cycle.
//    rd_req -> rd_valid latency is 2 cycles.
//  - rd_req outside IDLE is ignored; it is not queued.
//  - A new request is accepted only 1 cycle after the ack.
//  - rd_sel > N_NETS: rd_data=0, rd_sat=1 (error marker). Still a full handshake.
//  - rd_sel is sampled only in IDLE on rd_req.
//  - reset_L low mid-handshake: rd_valid drops asynchronously, FSM->IDLE.
//  - Counting continues during reads. The snapshot is the value at the LATCH
//    edge, including that cycle's increment.
// CONFIGURATION
//  FALL_COUNT_EN defined:
//    - Adds fall[i] = ~s2[i] & prev[i] and counters fcnt[i] (CNT_W, saturating).
//    - rd_sel = N_NETS+1+i reads fcnt[i].
//    - Out-of-range index moves to > 2*N_NETS.
//    - Falls never add to energy.
//  FALL_COUNT_EN undefined:
//    - No fall logic.
//    - rd_sel > N_NETS is the error case.
// TESTING
//  1 Reset: reset_L=0 mid-run -> rd_valid=0 at once; all reads after release
//    return 0, rd_sat=0.
//  2 Count: 5 pulses on nets[0], 3 on nets[2], enable=1 ->
//    read sel0=5, sel2=3, sel1=0, sel4 (energy)=8.
//  3 Simultaneous: all 4 nets rise together 10 times, E_PER_RISE=2 ->
//    each count 10, energy=80.
//  4 Saturation: CNT_W=4, 20 rises on nets[1] -> sel1=15, rd_sat=1.
//    clear -> 0, rd_sat=0.
//  5 Handshake: hold rd_ack=0 for 6 cycles while nets toggle ->
//    rd_data constant.
//    rd_req during PRESENT ignored; valid falls 1 cycle after ack.
//  6 Enable/clear: enable=0 plus 4 rises -> counts unchanged.
//    clear with a same-cycle rise -> count 0.
//    FALL_COUNT_EN: 3 pulses on nets[3] -> fcnt sel 8 = 3.

Source files
------------

// File: rtl/transition_energy_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : transition_energy_monitor
//  Description : Board-level switching-activity monitor. Synchronises a set
//                of asynchronous gate-output nets, detects 0->1 transitions,
//                keeps saturating per-net rise counts plus a weighted energy
//                total, and serves snapshot reads over req/valid/ack.
//  Ports       : clk      - system clock, rising edge
//                reset_L  - asynchronous active-low reset
//                nets     - monitored nets (asynchronous to clk)
//                enable   - 1: counting active, 0: counters/energy hold
//                clear    - synchronous pulse zeroing counters, energy, flags
//                rd_req   - read request (accepted in IDLE only)
//                rd_sel   - 0..N_NETS-1 rise count, N_NETS energy total
//                rd_valid - rd_data/rd_sat valid, held until rd_ack
//                rd_data  - zero-extended count or energy total
//                rd_sat   - selected counter saturated / out-of-range marker
//                rd_ack   - consumer accepted data
//  Options     : FALL_COUNT_EN - adds per-net falling-edge counters, read at
//                rd_sel = N_NETS+1+i; out-of-range moves to > 2*N_NETS.
//  Revision    : 1.0 - initial release
// ============================================================================
module transition_energy_monitor #(
    parameter int N_NETS     = 4,
    parameter int CNT_W      = 16,
    parameter int E_W        = 24,
    parameter int E_PER_RISE = 1
) (
    input  logic              clk,
    input  logic              reset_L,
    input  logic [N_NETS-1:0] nets,
    input  logic              enable,
    input  logic              clear,
    input  logic              rd_req,
    input  logic [3:0]        rd_sel,
    output logic              rd_valid,
    output logic [E_W-1:0]    rd_data,
    output logic              rd_sat,
    input  logic              rd_ack
);

    localparam int                 c_EXT_W   = E_W + 4;
    localparam logic [CNT_W-1:0]   c_CNT_MAX = '1;
    localparam logic [c_EXT_W-1:0] c_E_MAX   = {4'b0, {E_W{1'b1}}};

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LATCH   = 2'd1,
        ST_PRESENT = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Synchroniser and edge detect. Runs regardless of enable so that a
    // re-enable never sees a stale edge.
    // ------------------------------------------------------------------
    logic [N_NETS-1:0] r_s1, r_s2, r_prev;
    logic [N_NETS-1:0] w_rise;

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            r_s1   <= '0;
            r_s2   <= '0;
            r_prev <= '0;
        end else begin
            r_s1   <= nets;
            r_s2   <= r_s1;
            r_prev <= r_s2;
        end
    end

    assign w_rise = r_s2 & ~r_prev;

    // ------------------------------------------------------------------
    // Rise counters. Next-state values are exposed so that a snapshot taken
    // in LATCH includes the increment of that same cycle.
    // ------------------------------------------------------------------
    logic [N_NETS-1:0][CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [N_NETS-1:0]            r_sat, w_sat_nxt;

    always_comb begin
        w_cnt_nxt = r_cnt;
        w_sat_nxt = r_sat;
        for (int i = 0; i < N_NETS; i++) begin
            if (clear) begin
                w_cnt_nxt[i] = '0;
                w_sat_nxt[i] = 1'b0;
            end else if (enable && w_rise[i]) begin
                if (r_cnt[i] == c_CNT_MAX) w_sat_nxt[i] = 1'b1;
                else                       w_cnt_nxt[i] = r_cnt[i] + CNT_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Energy accumulator: widened by 4 bits so the overflow check is exact
    // even when several nets rise together.
    // ------------------------------------------------------------------
    logic [4:0]         w_pop;
    logic [c_EXT_W-1:0] w_e_sum;
    logic [E_W-1:0]     r_energy, w_e_nxt;
    logic               r_sat_e, w_sat_e_nxt;

    always_comb begin
        w_pop = '0;
        for (int i = 0; i < N_NETS; i++) begin
            w_pop = w_pop + 5'(w_rise[i]);
        end
    end

    assign w_e_sum = {4'b0, r_energy} + c_EXT_W'(E_PER_RISE) * c_EXT_W'(w_pop);

    always_comb begin
        w_e_nxt     = r_energy;
        w_sat_e_nxt = r_sat_e;
        if (clear) begin
            w_e_nxt     = '0;
            w_sat_e_nxt = 1'b0;
        end else if (enable) begin
            if (w_e_sum > c_E_MAX) begin
                w_e_nxt     = '1;
                w_sat_e_nxt = 1'b1;
            end else begin
                w_e_nxt = w_e_sum[E_W-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            r_cnt    <= '0;
            r_sat    <= '0;
            r_energy <= '0;
            r_sat_e  <= 1'b0;
        end else begin
            r_cnt    <= w_cnt_nxt;
            r_sat    <= w_sat_nxt;
            r_energy <= w_e_nxt;
            r_sat_e  <= w_sat_e_nxt;
        end
    end

`ifdef FALL_COUNT_EN
    // Falling-edge counters: counted like rises but never weighted into energy.
    logic [N_NETS-1:0]            w_fall;
    logic [N_NETS-1:0][CNT_W-1:0] r_fcnt, w_fcnt_nxt;
    logic [N_NETS-1:0]            r_fsat, w_fsat_nxt;

    assign w_fall = ~r_s2 & r_prev;

    always_comb begin
        w_fcnt_nxt = r_fcnt;
        w_fsat_nxt = r_fsat;
        for (int i = 0; i < N_NETS; i++) begin
            if (clear) begin
                w_fcnt_nxt[i] = '0;
                w_fsat_nxt[i] = 1'b0;
            end else if (enable && w_fall[i]) begin
                if (r_fcnt[i] == c_CNT_MAX) w_fsat_nxt[i] = 1'b1;
                else                        w_fcnt_nxt[i] = r_fcnt[i] + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            r_fcnt <= '0;
            r_fsat <= '0;
        end else begin
            r_fcnt <= w_fcnt_nxt;
            r_fsat <= w_fsat_nxt;
        end
    end
`endif

    // ------------------------------------------------------------------
    // Snapshot select. Any index not claimed below falls through to the
    // error marker (data 0, sat 1).
    // ------------------------------------------------------------------
    logic [3:0]     r_sel;
    logic [E_W-1:0] w_snap_data;
    logic           w_snap_sat;

    always_comb begin
        w_snap_data = '0;
        w_snap_sat  = 1'b1;
        for (int i = 0; i < N_NETS; i++) begin
            if (r_sel == 4'(i)) begin
                w_snap_data = E_W'(w_cnt_nxt[i]);
                w_snap_sat  = w_sat_nxt[i];
            end
        end
        if (r_sel == 4'(N_NETS)) begin
            w_snap_data = w_e_nxt;
            w_snap_sat  = w_sat_e_nxt;
        end
`ifdef FALL_COUNT_EN
        for (int i = 0; i < N_NETS; i++) begin
            if (r_sel == 4'(N_NETS + 1 + i)) begin
                w_snap_data = E_W'(w_fcnt_nxt[i]);
                w_snap_sat  = w_fsat_nxt[i];
            end
        end
`endif
    end

    // ------------------------------------------------------------------
    // Read handshake FSM
    // ------------------------------------------------------------------
    state_t         r_state;
    logic           r_rd_valid;
    logic [E_W-1:0] r_rd_data;
    logic           r_rd_sat;

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            r_state    <= ST_IDLE;
            r_sel      <= '0;
            r_rd_valid <= 1'b0;
            r_rd_data  <= '0;
            r_rd_sat   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (rd_req) begin
                        r_sel   <= rd_sel;
                        r_state <= ST_LATCH;
                    end
                end
                ST_LATCH: begin
                    r_rd_data  <= w_snap_data;
                    r_rd_sat   <= w_snap_sat;
                    r_rd_valid <= 1'b1;
                    r_state    <= ST_PRESENT;
                end
                ST_PRESENT: begin
                    if (rd_ack) begin
                        r_rd_valid <= 1'b0;
                        r_state    <= ST_IDLE;
                    end
                end
                default: begin
                    r_rd_valid <= 1'b0;
                    r_state    <= ST_IDLE;
                end
            endcase
        end
    end

    assign rd_valid = r_rd_valid;
    assign rd_data  = r_rd_data;
    assign rd_sat   = r_rd_sat;

endmodule
`default_nettype wire

// File: tb/tb_transition_energy_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : tb_transition_energy_monitor
//  Description : Scoreboard bench. Two instances share all inputs:
//                u_a uses defaults (CNT_W=16, E_PER_RISE=1),
//                u_b uses CNT_W=4, E_PER_RISE=2 (saturation / weighting).
//                Read tasks queue hand-computed expectations; a monitor pops
//                and compares whenever rd_valid is presented.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_transition_energy_monitor;

    logic        clk = 1'b0;
    logic        reset_L, enable, clear, rd_req, rd_ack;
    logic [3:0]  nets, rd_sel;
    logic        va, vb, sa, sb;
    logic [23:0] da, db;

    always #5 clk = ~clk;

    transition_energy_monitor #(
        .N_NETS(4), .CNT_W(16), .E_W(24), .E_PER_RISE(1)
    ) u_a (
        .clk(clk), .reset_L(reset_L), .nets(nets), .enable(enable),
        .clear(clear), .rd_req(rd_req), .rd_sel(rd_sel), .rd_valid(va),
        .rd_data(da), .rd_sat(sa), .rd_ack(rd_ack)
    );

    transition_energy_monitor #(
        .N_NETS(4), .CNT_W(4), .E_W(24), .E_PER_RISE(2)
    ) u_b (
        .clk(clk), .reset_L(reset_L), .nets(nets), .enable(enable),
        .clear(clear), .rd_req(rd_req), .rd_sel(rd_sel), .rd_valid(vb),
        .rd_data(db), .rd_sat(sb), .rd_ack(rd_ack)
    );

    int n_total = 0;
    int n_bad   = 0;

    typedef struct {
        logic [23:0] da;
        logic        sa;
        logic [23:0] db;
        logic        sb;
        int          tag;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_cur;
    bit   mon_active = 1'b0;
    bit   mon_have   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    // Monitor: pops one expectation per presentation and re-checks it every
    // cycle valid stays high, so held data must remain stable.
    always @(negedge clk) begin
        if (va) begin
            if (!mon_active) begin
                mon_active = 1'b1;
                mon_have   = (sb_q.size() != 0);
                if (mon_have) begin
                    mon_cur = sb_q.pop_front();
                end else begin
                    n_total++;
                    n_bad++;
                    $display("FAIL unexpected_valid: got rd_valid=1 want no presentation");
                end
            end
            if (mon_have) begin
                n_total++;
                if (vb !== 1'b1 || da !== mon_cur.da || sa !== mon_cur.sa ||
                    db !== mon_cur.db || sb !== mon_cur.sb) begin
                    n_bad++;
                    $display("FAIL read tag=%0d: got a=%0d/%0b b=%0d/%0b vb=%0b want a=%0d/%0b b=%0d/%0b vb=1",
                             mon_cur.tag, da, sa, db, sb, vb,
                             mon_cur.da, mon_cur.sa, mon_cur.db, mon_cur.sb);
                end
            end
        end else begin
            mon_active = 1'b0;
        end
    end

    task automatic start_read(input logic [3:0] sel, input int ea, input bit esa,
                              input int eb, input bit esb, input int tag);
        exp_t e;
        int   k;
        e.da  = 24'(ea);
        e.sa  = esa;
        e.db  = 24'(eb);
        e.sb  = esb;
        e.tag = tag;
        sb_q.push_back(e);
        @(negedge clk);
        rd_sel = sel;
        rd_req = 1'b1;
        @(negedge clk);
        rd_req = 1'b0;
        check("valid_early", {31'b0, va}, 32'd0);
        k = 0;
        while (!va && k < 10) begin
            @(negedge clk);
            k++;
        end
        check("read_latency", k, 32'd1);
    endtask

    task automatic finish_read(input int hold);
        repeat (hold) @(negedge clk);
        rd_ack = 1'b1;
        @(negedge clk);
        rd_ack = 1'b0;
        check("valid_drop", {30'b0, va, vb}, 32'd0);
        @(negedge clk);
    endtask

    task automatic read(input logic [3:0] sel, input int ea, input bit esa,
                        input int eb, input bit esb, input int tag);
        start_read(sel, ea, esa, eb, esb, tag);
        finish_read(0);
    endtask

    task automatic pulse(input logic [3:0] mask, input int n);
        repeat (n) begin
            @(negedge clk);
            nets = mask;
            @(negedge clk);
            @(negedge clk);
            nets = 4'b0;
            @(negedge clk);
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic do_clear();
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1);
    end

    initial begin
        bit seen;
        reset_L = 1'b0;
        enable  = 1'b1;
        clear   = 1'b0;
        rd_req  = 1'b0;
        rd_ack  = 1'b0;
        rd_sel  = 4'd0;
        nets    = 4'd0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_valid", {30'b0, va, vb}, 32'd0);
        check("rst_data_a", {8'b0, da}, 32'd0);
        check("rst_data_b", {8'b0, db}, 32'd0);
        check("rst_sat", {30'b0, sa, sb}, 32'd0);
        reset_L = 1'b1;
        repeat (2) @(negedge clk);

        // Counting: 5 rises on net0, 3 on net2
        pulse(4'b0001, 5);
        pulse(4'b0100, 3);
        read(4'd0, 5, 0, 5, 0, 20);
        read(4'd2, 3, 0, 3, 0, 21);
        read(4'd1, 0, 0, 0, 0, 22);
        read(4'd4, 8, 0, 16, 0, 23);
`ifdef FALL_COUNT_EN
        read(4'd5, 5, 0, 5, 0, 24);
`else
        read(4'd5, 0, 1, 0, 1, 24);
`endif
        read(4'd15, 0, 1, 0, 1, 25);

        // Reset in the middle of a handshake
        start_read(4'd0, 5, 0, 5, 0, 10);
        repeat (2) @(negedge clk);
        reset_L = 1'b0;
        #1;
        check("async_valid_drop", {30'b0, va, vb}, 32'd0);
        repeat (3) @(negedge clk);
        reset_L = 1'b1;
        repeat (3) @(negedge clk);
        read(4'd0, 0, 0, 0, 0, 11);
        read(4'd2, 0, 0, 0, 0, 12);
        read(4'd4, 0, 0, 0, 0, 13);

        // Simultaneous rises on all nets
        do_clear();
        pulse(4'b1111, 10);
        read(4'd0, 10, 0, 10, 0, 30);
        read(4'd3, 10, 0, 10, 0, 31);
        read(4'd4, 40, 0, 80, 0, 32);

        // Saturation (u_b has a 4-bit counter), then clear
        do_clear();
        pulse(4'b0010, 20);
        read(4'd1, 20, 0, 15, 1, 40);
        read(4'd4, 20, 0, 40, 0, 41);
        do_clear();
        read(4'd1, 0, 0, 0, 0, 42);

        // Held presentation while nets toggle; req during PRESENT ignored
        do_clear();
        pulse(4'b0001, 2);
        start_read(4'd0, 2, 0, 2, 0, 50);
        for (int c = 0; c < 6; c++) begin
            nets[0] = ~nets[0];
            rd_req  = (c == 3);
            rd_sel  = 4'd2;
            @(negedge clk);
        end
        rd_req = 1'b0;
        finish_read(0);
        seen = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (va) seen = 1'b1;
        end
        check("req_in_present_ignored", {31'b0, seen}, 32'd0);
        read(4'd0, 5, 0, 5, 0, 51);
        read(4'd4, 5, 0, 10, 0, 52);

        // Enable hold, then clear winning over a same-cycle rise
        do_clear();
        pulse(4'b1000, 2);
        enable = 1'b0;
        pulse(4'b1000, 4);
        enable = 1'b1;
        repeat (2) @(negedge clk);
        read(4'd3, 2, 0, 2, 0, 60);
        read(4'd4, 2, 0, 4, 0, 61);
        @(negedge clk);
        nets = 4'b1000;
        @(negedge clk);
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        nets  = 4'b0;
        repeat (4) @(negedge clk);
        read(4'd3, 0, 0, 0, 0, 62);
        read(4'd4, 0, 0, 0, 0, 63);
`ifdef FALL_COUNT_EN
        do_clear();
        pulse(4'b1000, 3);
        read(4'd8, 3, 0, 3, 0, 64);
`endif

        repeat (5) @(negedge clk);
        check("queue_empty", sb_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
